// File: rtl/icache_defines.sv
// Shared definitions for the direct-mapped instruction cache: FSM encodings,
// line geometry and the word-select helper.
package icache_defines;

  localparam int ADDR_W         = 16;
  localparam int WORD_W         = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_W         = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } state_e;

  // Word 0 sits in the low 16 bits of a refilled line.
  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [1:0]        off);
    logic [WORD_W-1:0] w;
    case (off)
      2'd0:    w = line[15:0];
      2'd1:    w = line[31:16];
      2'd2:    w = line[47:32];
      default: w = line[63:48];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage for the instruction cache: one combinational read
// port, one whole-line write port and a global valid-clear.
module icache_array
  import icache_defines::*;
#(
  parameter int INDEX_BITS = 5,
  parameter int TAG_W      = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic                  rd_valid_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [LINE_W-1:0]     rd_line_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]      wr_tag_i,
  input  logic [LINE_W-1:0]     wr_line_i,
  input  logic                  wr_valid_i,
  input  logic                  clr_i
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  // A line write in the same cycle as a clear takes priority for that line;
  // the controller already drives wr_valid_i low when a clear is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (clr_i)   valid_q           <= '0;
      if (wr_en_i) valid_q[wr_idx_i] <= wr_valid_i;
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: zero-latency hit path, miss FSM
// with line refill. Optional hit/miss counters under `ICACHE_PERF_EN.
module icache_ctrl
  import icache_defines::*;
#(
  parameter int INDEX_BITS = 5,
  parameter int MEM_ADDR_W = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic                  i_rdEn,
  input  logic                  i_inv,
  output logic [WORD_W-1:0]     o_instr,
  output logic                  o_stall,
  output logic [MEM_ADDR_W-1:0] o_memAddr,
  output logic                  o_memRd,
  input  logic [LINE_W-1:0]     i_memData,
  input  logic                  i_memRdy,
  output logic [15:0]           o_hitCnt,
  output logic [15:0]           o_missCnt
);

  localparam int TAG_W = ADDR_W - 2 - INDEX_BITS;

  state_e                  state_q, state_d;
  logic [MEM_ADDR_W-1:0]   miss_addr_q, miss_addr_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic                    inv_pending_q, inv_pending_d;

  logic [INDEX_BITS-1:0]   lk_idx;
  logic [TAG_W-1:0]        lk_tag;
  logic                    rd_valid;
  logic [TAG_W-1:0]        rd_tag;
  logic [LINE_W-1:0]       rd_line;
  logic                    hit;
  logic                    arr_wr_en;
  logic                    miss_start;

  assign lk_idx = i_addr[INDEX_BITS+1:2];
  assign lk_tag = i_addr[ADDR_W-1:INDEX_BITS+2];

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (lk_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .wr_en_i    (arr_wr_en),
    .wr_idx_i   (miss_addr_q[INDEX_BITS-1:0]),
    .wr_tag_i   (miss_addr_q[MEM_ADDR_W-1:INDEX_BITS]),
    .wr_line_i  (line_q),
    .wr_valid_i (~(inv_pending_q | i_inv)),
    .clr_i      (i_inv)
  );

  // Hits are only honoured in IDLE so a refill never races a lookup.
  assign hit     = i_rdEn & rd_valid & (rd_tag == lk_tag) & (state_q == IDLE);
  assign o_instr = hit ? word_sel(rd_line, i_addr[1:0]) : '0;
  assign o_stall = i_rdEn & ~hit;

  // NOTE: state registers use non-blocking assignments; next-state logic below uses blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      miss_addr_q   <= '0;
      line_q        <= '0;
      inv_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      miss_addr_q   <= miss_addr_d;
      line_q        <= line_d;
      inv_pending_q <= inv_pending_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    miss_addr_d   = miss_addr_q;
    line_d        = line_q;
    inv_pending_d = inv_pending_q;
    arr_wr_en     = 1'b0;
    o_memRd       = 1'b0;
    miss_start    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_rdEn && !hit) begin
          miss_addr_d = i_addr[ADDR_W-1:2];
          miss_start  = 1'b1;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        o_memRd = 1'b1;
        if (i_inv) inv_pending_d = 1'b1;
        if (i_memRdy) begin
          line_d  = i_memData;
          state_d = FILL;
        end
      end
      FILL: begin
        arr_wr_en     = 1'b1;
        inv_pending_d = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_memAddr = miss_addr_q;

`ifdef ICACHE_PERF_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit && hit_cnt_q != 16'hFFFF)         hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (miss_start && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign o_hitCnt  = hit_cnt_q;
  assign o_missCnt = miss_cnt_q;
`else
  assign o_hitCnt  = 16'h0000;
  assign o_missCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed self-checking bench for icache_ctrl with hand-computed expectations.
module tb_icache_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] i_addr;
  logic        i_rdEn;
  logic        i_inv;
  logic [15:0] o_instr;
  logic        o_stall;
  logic [13:0] o_memAddr;
  logic        o_memRd;
  logic [63:0] i_memData;
  logic        i_memRdy;
  logic [15:0] o_hitCnt;
  logic [15:0] o_missCnt;

  int n_cmp = 0;
  int n_bad = 0;

  icache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .i_addr    (i_addr),
    .i_rdEn    (i_rdEn),
    .i_inv     (i_inv),
    .o_instr   (o_instr),
    .o_stall   (o_stall),
    .o_memAddr (o_memAddr),
    .o_memRd   (o_memRd),
    .i_memData (i_memData),
    .i_memRdy  (i_memRdy),
    .o_hitCnt  (o_hitCnt),
    .o_missCnt (o_missCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called while in FETCH: wait lat cycles with the request held, then return the line.
  task automatic serve(input logic [63:0] data, input int lat, input logic [13:0] exp_addr);
    for (int i = 0; i < lat; i++) begin
      check("memrd_hold", o_memRd, 1'b1);
      check("memaddr_hold", o_memAddr, exp_addr);
      step();
    end
    i_memData = data;
    i_memRdy  = 1'b1;
    step();
    i_memRdy  = 1'b0;
    check("memrd_drop", o_memRd, 1'b0);
    check("fill_stall", o_stall, i_rdEn);
    step();
  endtask

  initial begin
    rst = 1'b1; i_addr = '0; i_rdEn = 1'b0; i_inv = 1'b0;
    i_memData = '0; i_memRdy = 1'b0;
    #12;
    check("rst_memrd", o_memRd, 1'b0);
    check("rst_memaddr", o_memAddr, 14'h0);
    check("rst_stall", o_stall, 1'b0);
    check("rst_instr", o_instr, 16'h0);
    check("rst_hitcnt", o_hitCnt, 16'h0);
    check("rst_misscnt", o_missCnt, 16'h0);
    step();
    rst = 1'b0;
    step();
    check("idle_nordEn_stall", o_stall, 1'b0);

    // Cold miss on 0x0005, line returned after three FETCH cycles.
    i_addr = 16'h0005; i_rdEn = 1'b1;
    #1;
    check("cold_stall", o_stall, 1'b1);
    check("cold_instr", o_instr, 16'h0);
    step();
    check("cold_memrd", o_memRd, 1'b1);
    check("cold_memaddr", o_memAddr, 14'h0001);
    serve(64'hDDDD_CCCC_BBBB_AAAA, 3, 14'h0001);
    check("cold_hit_stall", o_stall, 1'b0);
    check("cold_hit_instr", o_instr, 16'hBBBB);
    step();

    // Same-line hits.
    i_addr = 16'h0004; #1;
    check("hit4_stall", o_stall, 1'b0);
    check("hit4_instr", o_instr, 16'hAAAA);
    step();
    i_addr = 16'h0007; #1;
    check("hit7_stall", o_stall, 1'b0);
    check("hit7_instr", o_instr, 16'hDDDD);
    step();
`ifdef ICACHE_PERF_EN
    check("perf_hitcnt", o_hitCnt, 16'd3);
    check("perf_misscnt", o_missCnt, 16'd1);
`else
    check("noperf_hitcnt", o_hitCnt, 16'd0);
    check("noperf_misscnt", o_missCnt, 16'd0);
`endif

    // Conflict eviction: 0x0084 shares index 1 with 0x0004.
    i_addr = 16'h0084; #1;
    check("conf_stall", o_stall, 1'b1);
    step();
    check("conf_memaddr", o_memAddr, 14'h0021);
    serve(64'h4444_3333_2222_1111, 0, 14'h0021);
    check("conf_instr", o_instr, 16'h1111);
    step();
    i_addr = 16'h0004; #1;
    check("evict_stall", o_stall, 1'b1);
    step();
    check("evict_memaddr", o_memAddr, 14'h0001);
    serve(64'hDDDD_CCCC_BBBB_AAAA, 1, 14'h0001);
    check("evict_instr", o_instr, 16'hAAAA);
    step();

    // Invalidate during FETCH: the refilled line is written invalid.
    i_addr = 16'h0008; #1;
    step();
    check("inv_memrd", o_memRd, 1'b1);
    i_inv = 1'b1;
    step();
    i_inv = 1'b0;
    serve(64'h8888_7777_6666_5555, 1, 14'h0002);
    check("inv_relookup_stall", o_stall, 1'b1);
    step();
    check("inv_rereq_memrd", o_memRd, 1'b1);
    check("inv_rereq_memaddr", o_memAddr, 14'h0002);
    serve(64'h8888_7777_6666_5555, 0, 14'h0002);
    check("inv_final_instr", o_instr, 16'h5555);
    step();

    // Redirect mid-miss: refill completes for 0x0010, then 0x0100 misses.
    i_addr = 16'h0010; #1;
    step();
    check("redir_memaddr0", o_memAddr, 14'h0004);
    i_addr = 16'h0100;
    step();
    serve(64'h0000_0000_0000_CAFE, 1, 14'h0004);
    check("redir_new_stall", o_stall, 1'b1);
    step();
    check("redir_new_memaddr", o_memAddr, 14'h0040);
    serve(64'h0000_0000_0000_BEEF, 0, 14'h0040);
    check("redir_new_instr", o_instr, 16'hBEEF);
    step();
    i_addr = 16'h0010; #1;
    check("redir_old_instr", o_instr, 16'hCAFE);

    // Invalidate in IDLE: same-cycle lookup still hits, next one misses.
    i_inv = 1'b1; #1;
    check("idle_inv_stall", o_stall, 1'b0);
    check("idle_inv_instr", o_instr, 16'hCAFE);
    step();
    i_inv = 1'b0; #1;
    check("post_inv_stall", o_stall, 1'b1);
    step();
    check("pre_rst_memrd", o_memRd, 1'b1);

    // Reset mid-refill, followed by a late memory response.
    rst = 1'b1; #1;
    check("midrst_memrd", o_memRd, 1'b0);
    check("midrst_memaddr", o_memAddr, 14'h0);
    check("midrst_hitcnt", o_hitCnt, 16'h0);
    step();
    rst = 1'b0; i_rdEn = 1'b0;
    i_memData = 64'h0000_0000_0000_DEAD; i_memRdy = 1'b1;
    step();
    i_memRdy = 1'b0;
    check("late_rdy_memrd", o_memRd, 1'b0);
    i_rdEn = 1'b1; #1;
    check("post_rst_stall", o_stall, 1'b1);
    check("post_rst_instr", o_instr, 16'h0);
    step();
    check("post_rst_memrd", o_memRd, 1'b1);
    serve(64'h0000_0000_0000_CAFE, 0, 14'h0004);
    check("post_rst_hit", o_instr, 16'hCAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
